// File: rtl/ps2_msg_arbiter.sv
// Two-port PS/2 3-byte message framer with per-port message FIFOs and a round-robin valid/ready output.
// Optional inter-byte gap timeout is built only when PS2_TIMEOUT_EN is defined.
module ps2_msg_arbiter #(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  in_valid,
    input  logic [7:0]  in_data0,
    input  logic [7:0]  in_data1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_msg,
    output logic        out_port,
    output logic [1:0]  overflow,
    input  logic [1:0]  clr_ovf,
    output logic [1:0]  timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {SYNC, BYTE2, BYTE3} frm_state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ps2_msg_arbiter: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
    end

    logic [1:0][7:0]  data;
    logic [1:0][23:0] head;
    logic [1:0]       empty;
    logic [1:0]       pop;
    logic             grant;
    logic             xfer;

    assign data = {in_data1, in_data0};

    for (genvar p = 0; p < 2; p++) begin : g_port
        frm_state_e     state_q;
        logic [7:0]     b0_q, b1_q;
        logic [23:0]    mem_q [DEPTH];
        logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
        logic [AW:0]    count_q;
        logic           ovf_q;
        logic           tmo_fire;
        logic           push, push_ok, full;

`ifdef PS2_TIMEOUT_EN
        localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
        logic [TW-1:0] gap_q;
        logic          tmo_q;

        assign tmo_fire = (state_q != SYNC) && (gap_q == TW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                gap_q <= '0;
                tmo_q <= 1'b0;
            end else begin
                tmo_q <= tmo_fire;
                if (in_valid[p] || state_q == SYNC || tmo_fire) gap_q <= '0;
                else                                              gap_q <= gap_q + 1'b1;
            end
        end
        assign timeout[p] = tmo_q;
`else
        assign tmo_fire   = 1'b0;
        assign timeout[p] = 1'b0;
`endif

        // A byte landing on the timeout cycle is framed as if the framer were already in SYNC.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= SYNC;
                b0_q    <= '0;
                b1_q    <= '0;
            end else if (in_valid[p]) begin
                if (state_q == SYNC || tmo_fire) begin
                    if (data[p][3]) begin
                        b0_q    <= data[p];
                        state_q <= BYTE2;
                    end else begin
                        state_q <= SYNC;
                    end
                end else if (state_q == BYTE2) begin
                    b1_q    <= data[p];
                    state_q <= BYTE3;
                end else begin
                    state_q <= SYNC;
                end
            end else if (tmo_fire) begin
                state_q <= SYNC;
            end
        end

        assign push     = in_valid[p] && (state_q == BYTE3) && !tmo_fire;
        assign full     = (count_q == FULL_CNT);
        assign push_ok  = push && (!full || pop[p]);
        assign empty[p] = (count_q == '0);
        assign head[p]  = mem_q[rd_ptr_q];
        assign overflow[p] = ovf_q;

        always_ff @(posedge clk) begin
            if (push_ok) mem_q[wr_ptr_q] <= {b0_q, b1_q, data[p]};
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop[p])  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop[p]};
                ovf_q   <= (push && full && !pop[p]) || (ovf_q && !clr_ovf[p]);
            end
        end
    end

    logic        ptr_q, grant_q, locked_q;
    logic [23:0] last_msg_q;
    logic        last_port_q;

    // While a stalled offer is pending the grant is frozen so the head cannot change under the consumer.
    always_comb begin
        grant = ptr_q;
        if (locked_q)                           grant = grant_q;
        else if (empty[ptr_q] && !empty[~ptr_q]) grant = ~ptr_q;
    end

    assign out_valid = !empty[grant];
    assign out_msg   = out_valid ? head[grant] : last_msg_q;
    assign out_port  = out_valid ? grant : last_port_q;
    assign xfer      = out_valid && out_ready;
    assign pop       = {xfer && grant, xfer && !grant};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= 1'b0;
            grant_q     <= 1'b0;
            locked_q    <= 1'b0;
            last_msg_q  <= '0;
            last_port_q <= 1'b0;
        end else begin
            locked_q <= out_valid && !out_ready;
            grant_q  <= grant;
            if (xfer) ptr_q <= ~grant;
            if (out_valid) begin
                last_msg_q  <= head[grant];
                last_port_q <= grant;
            end
        end
    end
endmodule

// File: tb/tb_ps2_msg_arbiter.sv
// Self-checking bench for ps2_msg_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_ps2_msg_arbiter;
    localparam int DEPTH = 2;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [7:0]  in_data0, in_data1;
    logic        out_ready;
    logic [1:0]  clr_ovf;
    logic        out_valid;
    logic [23:0] out_msg;
    logic        out_port;
    logic [1:0]  overflow, timeout;

    ps2_msg_arbiter #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_port(out_port),
        .overflow(overflow), .clr_ovf(clr_ovf), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] mq0[$];
    logic [23:0] mq1[$];
    int          fstage [2];
    logic [7:0]  fb0 [2];
    logic [7:0]  fb1 [2];
    longint      last_byte [2];
    longint      cyc = 0;
    logic        m_valid, m_port, m_locked, m_lport, m_pref;
    logic [23:0] m_msg;
    logic [1:0]  m_ovf, m_tmo;

    function automatic int qsize(logic p);
        return p ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [23:0] qhead(logic p);
        return p ? mq1[0] : mq0[0];
    endfunction

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        for (int p = 0; p < 2; p++) begin
            fstage[p] = 0; fb0[p] = '0; fb1[p] = '0; last_byte[p] = 0;
        end
        m_valid = 0; m_port = 0; m_locked = 0; m_lport = 0; m_pref = 0;
        m_msg = '0; m_ovf = '0; m_tmo = '0;
    endtask

    task automatic model_step();
        logic [7:0]  d [2];
        logic [1:0]  nov;
        logic [23:0] msg;
        cyc++;
        d[0] = in_data0;
        d[1] = in_data1;
        if (m_valid && out_ready) begin
            if (m_port) void'(mq1.pop_front());
            else        void'(mq0.pop_front());
            m_pref   = !m_port;
            m_locked = 0;
        end else if (m_valid) begin
            m_locked = 1;
            m_lport  = m_port;
        end else begin
            m_locked = 0;
        end
        m_tmo = '0;
        for (int p = 0; p < 2; p++) begin
            bit done;
            done = 0;
            msg  = '0;
`ifdef PS2_TIMEOUT_EN
            if (fstage[p] != 0 && (cyc - last_byte[p]) == TMO) begin
                fstage[p] = 0;
                m_tmo[p]  = 1'b1;
            end
`endif
            if (in_valid[p]) begin
                last_byte[p] = cyc;
                case (fstage[p])
                    0: if (d[p][3]) begin fb0[p] = d[p]; fstage[p] = 1; end
                    1: begin fb1[p] = d[p]; fstage[p] = 2; end
                    default: begin msg = {fb0[p], fb1[p], d[p]}; done = 1; fstage[p] = 0; end
                endcase
            end
            nov[p] = m_ovf[p] & ~clr_ovf[p];
            if (done) begin
                if (qsize(p[0]) < DEPTH) begin
                    if (p == 1) mq1.push_back(msg);
                    else        mq0.push_back(msg);
                end else begin
                    nov[p] = 1'b1;
                end
            end
        end
        m_ovf = nov;
        if (m_locked) begin
            m_valid = 1; m_port = m_lport;
        end else if (qsize(m_pref) > 0) begin
            m_valid = 1; m_port = m_pref;
        end else if (qsize(!m_pref) > 0) begin
            m_valid = 1; m_port = !m_pref;
        end else begin
            m_valid = 0;
        end
        if (m_valid) m_msg = qhead(m_port);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, m_valid);
        check("out_msg",   out_msg,   m_msg);
        check("out_port",  out_port,  m_port);
        check("overflow",  overflow,  m_ovf);
        check("timeout",   timeout,   m_tmo);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 2'b00;
        repeat (n) tick();
    endtask

    task automatic send(int p, logic [7:0] b);
        in_valid = 2'b00;
        if (p == 0) begin in_valid[0] = 1'b1; in_data0 = b; end
        else        begin in_valid[1] = 1'b1; in_data1 = b; end
        tick();
        in_valid = 2'b00;
    endtask

    task automatic send_msg(int p, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        send(p, a); send(p, b); send(p, c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 2'b00;
        clr_ovf = 2'b00;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; in_valid = 2'b00; in_data0 = '0; in_data1 = '0;
        out_ready = 1'b0; clr_ovf = 2'b00;
        #2 reset = 1'b1;
        tick(); tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_msg",   out_msg,   0);
        check("reset_overflow",  overflow,  0);
        reset = 1'b0;
        tick();

        // basic framing and latency
        out_ready = 1'b1;
        send_msg(0, 8'h08, 8'h12, 8'h34);
        check("basic_valid", out_valid, 1);
        check("basic_msg",   out_msg,   24'h081234);
        check("basic_port",  out_port,  0);
        tick();
        check("basic_popped", out_valid, 0);

        // resync: leading bytes with bit3 clear are discarded
        send(0, 8'h01); send(0, 8'h02);
        check("resync_no_msg", out_valid, 0);
        send_msg(0, 8'h0F, 8'hAA, 8'h55);
        check("resync_msg", out_msg, 24'h0FAA55);
        tick();
        check("resync_single", out_valid, 0);

        // simultaneous completion after reset: port 0 first
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b11; in_data0 = 8'h08; in_data1 = 8'h18; tick();
        in_valid = 2'b11; in_data0 = 8'hAA; in_data1 = 8'hCC; tick();
        in_valid = 2'b11; in_data0 = 8'hBB; in_data1 = 8'hDD; tick();
        in_valid = 2'b00;
        check("simul_first_port", out_port, 0);
        check("simul_first_msg",  out_msg,  24'h08AABB);
        tick();
        check("simul_second_port", out_port, 1);
        check("simul_second_msg",  out_msg,  24'h18CCDD);
        tick();
        check("simul_drained", out_valid, 0);

        // stall: offer held while port 1 completes behind it
        out_ready = 1'b0;
        send_msg(0, 8'h09, 8'h21, 8'h43);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) send(1, (i == 0) ? 8'h1A : 8'h60 + 8'(i));
            else       tick();
            check("hold_msg",  out_msg,  24'h092143);
            check("hold_port", out_port, 0);
        end
        out_ready = 1'b1;
        tick();
        check("after_hold_port", out_port, 1);
        check("after_hold_msg",  out_msg,  24'h1A6162);
        tick();
        check("after_hold_empty", out_valid, 0);

        // overflow with DEPTH+1 messages
        do_reset();
        out_ready = 1'b0;
        for (int m = 1; m <= DEPTH + 1; m++) send_msg(0, 8'h08, 8'(m), 8'(m));
        check("ovf_set", overflow, 2'b01);
        clr_ovf = 2'b01; tick(); clr_ovf = 2'b00;
        check("ovf_cleared", overflow, 2'b00);
        send(0, 8'h08); send(0, 8'h04);
        clr_ovf = 2'b01; send(0, 8'h04); clr_ovf = 2'b00;
        check("ovf_set_wins", overflow, 2'b01);
        out_ready = 1'b1;
        check("drain_first", out_msg, 24'h080101);
        tick();
        check("drain_second", out_msg, 24'h080202);
        tick();
        check("drain_empty", out_valid, 0);
        clr_ovf = 2'b01; tick(); clr_ovf = 2'b00;

`ifdef PS2_TIMEOUT_EN
        do_reset();
        out_ready = 1'b1;
        send(1, 8'h08);
        idle(TMO - 1);
        check("tmo_not_yet", timeout, 2'b00);
        tick();
        check("tmo_pulse", timeout, 2'b10);
        tick();
        check("tmo_single", timeout, 2'b00);
        check("tmo_no_msg", out_valid, 0);
        send_msg(1, 8'h08, 8'h01, 8'h02);
        check("tmo_after_msg",  out_msg,  24'h080102);
        check("tmo_after_port", out_port, 1);
        tick();
`endif

        // reset mid-message
        send(0, 8'h08); send(0, 8'h11);
        do_reset();
        send(0, 8'h33);
        check("midreset_discard", out_valid, 0);

        // dense random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 2'($urandom_range(0, 3));
            in_data0  = 8'($urandom);
            in_data1  = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_ovf   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick();
        end
        // sparse random traffic, long gaps
        for (int i = 0; i < 1500; i++) begin
            in_valid[0] = ($urandom_range(0, 11) == 0);
            in_valid[1] = ($urandom_range(0, 11) == 0);
            in_data0  = 8'($urandom);
            in_data1  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00;
            tick();
        end
        in_valid = 2'b00;
        out_ready = 1'b1;
        idle(2 * DEPTH + 4);
        check("final_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
